// File: rtl/lfsr_loader.sv
// Serial seed/tap loader feeding a Galois LFSR; the word commits one edge after its last bit, with a one-cycle reset_*_o pulse.
// The host paces bits with valid_i and there is no timeout. Defining LFSR_LOADER_PARITY_EN adds a trailing even-parity bit.
module lfsr_loader #(
    parameter int              BITS         = 8,
    parameter logic [BITS-1:0] DEFAULT_SEED = 8'h01,
    parameter logic [BITS-1:0] DEFAULT_TAPS = 8'hB8
) (
    input  logic            clk,
    input  logic            reset_i,
    input  logic            start_i,
    input  logic            target_i,
    input  logic            valid_i,
    input  logic            data_i,
    output logic            busy_o,
    output logic            error_o,
    output logic [BITS-1:0] seed_o,
    output logic [BITS-1:0] taps_o,
    output logic            reset_lfsr_o,
    output logic            reset_taps_o
);

    localparam int              CW       = $clog2(BITS + 1);
    localparam logic [CW-1:0]   CNT_FULL = CW'(BITS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [BITS-1:0] sr_q, sr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            tgt_q, tgt_d;
    logic [BITS-1:0] seed_q, seed_d;
    logic [BITS-1:0] taps_q, taps_d;
    logic            busy_q, busy_d;
    logic            error_q, error_d;
    logic            rst_lfsr_q, rst_lfsr_d;
    logic            rst_taps_q, rst_taps_d;
    logic            word_done;
    logic            reject;

`ifdef LFSR_LOADER_PARITY_EN
    logic            par_q, par_d;
    logic            par_seen_q, par_seen_d;

    assign word_done = (cnt_q == CNT_FULL) && par_seen_q;
    assign reject    = (!tgt_q && (sr_q == '0)) || (par_q != (^sr_q));
`else
    assign word_done = (cnt_q == CNT_FULL);
    assign reject    = !tgt_q && (sr_q == '0);
`endif

    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        cnt_d      = cnt_q;
        tgt_d      = tgt_q;
        seed_d     = seed_q;
        taps_d     = taps_q;
        busy_d     = busy_q;
        error_d    = error_q;
        rst_lfsr_d = 1'b0;
        rst_taps_d = 1'b0;
`ifdef LFSR_LOADER_PARITY_EN
        par_d      = par_q;
        par_seen_d = par_seen_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d    = SHIFT;
                    tgt_d      = target_i;
                    sr_d       = '0;
                    cnt_d      = '0;
                    error_d    = 1'b0;
                    busy_d     = 1'b1;
`ifdef LFSR_LOADER_PARITY_EN
                    par_seen_d = 1'b0;
`endif
                end
            end
            SHIFT: begin
                if (word_done) begin
                    // A rejected word leaves both output registers and pulses untouched.
                    if (reject) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        error_d = 1'b1;
                    end else begin
                        state_d = COMMIT;
                        if (tgt_q) begin
                            taps_d     = sr_q;
                            rst_taps_d = 1'b1;
                        end else begin
                            seed_d     = sr_q;
                            rst_lfsr_d = 1'b1;
                        end
                    end
                end else if (valid_i) begin
`ifdef LFSR_LOADER_PARITY_EN
                    if (cnt_q == CNT_FULL) begin
                        par_d      = data_i;
                        par_seen_d = 1'b1;
                    end else begin
                        sr_d  = {data_i, sr_q[BITS-1:1]};
                        cnt_d = cnt_q + CW'(1);
                    end
`else
                    sr_d  = {data_i, sr_q[BITS-1:1]};
                    cnt_d = cnt_q + CW'(1);
`endif
                end
            end
            COMMIT: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Reset holds both LFSR reset pulses high so the defaults load into the LFSR.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            state_q    <= IDLE;
            sr_q       <= '0;
            cnt_q      <= '0;
            tgt_q      <= 1'b0;
            seed_q     <= DEFAULT_SEED;
            taps_q     <= DEFAULT_TAPS;
            busy_q     <= 1'b0;
            error_q    <= 1'b0;
            rst_lfsr_q <= 1'b1;
            rst_taps_q <= 1'b1;
`ifdef LFSR_LOADER_PARITY_EN
            par_q      <= 1'b0;
            par_seen_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            cnt_q      <= cnt_d;
            tgt_q      <= tgt_d;
            seed_q     <= seed_d;
            taps_q     <= taps_d;
            busy_q     <= busy_d;
            error_q    <= error_d;
            rst_lfsr_q <= rst_lfsr_d;
            rst_taps_q <= rst_taps_d;
`ifdef LFSR_LOADER_PARITY_EN
            par_q      <= par_d;
            par_seen_q <= par_seen_d;
`endif
        end
    end

    assign busy_o       = busy_q;
    assign error_o      = error_q;
    assign seed_o       = seed_q;
    assign taps_o       = taps_q;
    assign reset_lfsr_o = rst_lfsr_q;
    assign reset_taps_o = rst_taps_q;

endmodule
